// File: rtl/sdram_master_arbiter_pkg.sv
// Shared types for the two-requester SDRAM master arbiter.
// Optional build macro used by the arbiter: ARB_FIXED_PRIO_EN (m0 always wins ties).
package sdram_arb_pkg;

  localparam int NUM_REQ = 2;

  // Requester id: 0 = wordcopy (m0), 1 = DNN compute engine (m1).
  typedef logic req_id_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // With two requesters the round-robin choice is simply "the other one".
  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/sdram_master_arbiter_if.sv
// Avalon-MM pipelined-read port bundle, used both for the requester-facing
// ports and for the SDRAM-facing port of the arbiter.
//
// Handshake: a command (read or write strobe with address/data) is accepted on
// a rising clk edge where the strobe is high and waitrequest is low. While
// waitrequest is high the issuer holds the command stable. Read data returns
// later, one word per cycle with readdatavalid high, in issue order.
interface sdram_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              waitrequest;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  // Side that issues commands.
  modport master (
    input  waitrequest, readdata, readdatavalid,
    output address, read, write, writedata
  );

  // Side that receives commands.
  modport slave (
    output waitrequest, readdata, readdatavalid,
    input  address, read, write, writedata
  );
endinterface

// File: rtl/sdram_master_arbiter_id_fifo.sv
// Small FIFO of requester ids, one entry per outstanding read, so returning
// read data can be steered to the requester that issued it.
module arb_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  req_id_t          din,
  input  logic             pop,
  output req_id_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  req_id_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sdram_master_arbiter.sv
// Shares one Avalon-MM SDRAM master port between m0 (wordcopy) and m1 (DNN
// compute engine). Commands pass through combinationally; a command stalled by
// the SDRAM locks the grant to its issuer until accepted. Read ids are queued so
// readdatavalid is routed back to the issuer.
// Build macro: ARB_FIXED_PRIO_EN -- when defined, m0 always wins ties.
module sdram_master_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 8,
  localparam int CNT_W  = $clog2(MAX_OUT) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdram_master_arbiter_if.slave  m0,
  sdram_master_arbiter_if.slave  m1,
  sdram_master_arbiter_if.master s,
  output logic                  err,
  output arb_state_t            dbg_state,
  output logic [CNT_W-1:0]      dbg_count
);

  arb_state_t           state_q, state_d;
  req_id_t              owner_q, owner_d;
  req_id_t              last_q, last_d;
  logic                 err_q, err_d;
  req_id_t              winner;
  logic                 fwd;
  logic                 accept;
  logic [NUM_REQ-1:0]   rd, wr, req, elig;
  logic [ADDR_W-1:0]    mux_addr;
  logic [DATA_W-1:0]    mux_wdata;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  req_id_t              fifo_head;

  assign rd   = {m1.read, m0.read};
  assign wr   = {m1.write, m0.write};
  assign req  = rd | wr;
  // A request carrying a read strobe cannot be taken while every id slot is used.
  assign elig = req & ~(rd & {NUM_REQ{fifo_full}});

  // Grant selection: open arbitration in IDLE, held owner in LOCKED.
  always_comb begin
    winner = 1'b0;
    fwd    = 1'b0;
    if (rst_n) begin
      if (state_q == ARB_IDLE) begin
        fwd = |elig;
        if (&elig) begin
`ifdef ARB_FIXED_PRIO_EN
          winner = 1'b0;
`else
          winner = other_id(last_q);
`endif
        end else begin
          winner = elig[1];
        end
      end else begin
        winner = owner_q;
        fwd    = req[owner_q];
      end
    end
  end

  assign mux_addr  = winner ? m1.address   : m0.address;
  assign mux_wdata = winner ? m1.writedata : m0.writedata;

  // read has precedence when a requester raises both strobes.
  assign s.address   = mux_addr;
  assign s.writedata = mux_wdata;
  assign s.read      = fwd && rd[winner];
  assign s.write     = fwd && wr[winner] && !rd[winner];

  assign m0.waitrequest = (fwd && winner == 1'b0) ? s.waitrequest : 1'b1;
  assign m1.waitrequest = (fwd && winner == 1'b1) ? s.waitrequest : 1'b1;

  assign accept    = fwd && !s.waitrequest;
  assign fifo_push = accept && rd[winner];
  assign fifo_pop  = rst_n && s.readdatavalid && !fifo_empty;

  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = fifo_pop && (fifo_head == 1'b0);
  assign m1.readdatavalid = fifo_pop && (fifo_head == 1'b1);

  arb_id_fifo #(.DEPTH(MAX_OUT)) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (winner),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (dbg_count)
  );

  // Next-state: lock on a stalled command, release and remember the last grant on accept.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q || (s.readdatavalid && fifo_empty) || (|(rd & wr));
    case (state_q)
      ARB_IDLE: begin
        if (fwd) begin
          if (s.waitrequest) begin
            state_d = ARB_LOCKED;
            owner_d = winner;
          end else begin
            last_d = winner;
          end
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register; last resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_master_arbiter.sv
// Directed bench for sdram_master_arbiter: round-robin grants, lock on stall,
// read-return routing through a scoreboard queue, full-FIFO stall, error flag
// and reset behaviour.
module tb_sdram_master_arbiter;
  import sdram_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAX_OUT = 8;
  localparam int W = DATA_W + 1;

  logic       clk;
  logic       rst_n;
  logic       err;
  arb_state_t dbg_state;
  logic [3:0] dbg_count;

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];
  req_id_t exp_last;
  req_id_t exp_w;
  logic [W-1:0] ent;

  sdram_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  sdram_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  sdram_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

  sdram_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .err       (err),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_if.read = 1'b0; m0_if.write = 1'b0;
    m1_if.read = 1'b0; m1_if.write = 1'b0;
    s_if.waitrequest = 1'b0;
    s_if.readdatavalid = 1'b0;
  endtask

  task automatic set_read(input req_id_t id, input logic [31:0] addr, input logic v);
    if (id == 1'b0) begin m0_if.read = v; m0_if.address = addr; end
    else            begin m1_if.read = v; m1_if.address = addr; end
  endtask

  // Issue one read from requester id; queue the data the SDRAM will return for it.
  task automatic issue_read(input req_id_t id, input logic [31:0] addr, input logic [31:0] rdata);
    set_read(id, addr, 1'b1);
    #2;
    chk("rd_s_read", s_if.read, 1'b1);
    chk("rd_s_addr", s_if.address, addr);
    chk("rd_wait", (id == 1'b0) ? m0_if.waitrequest : m1_if.waitrequest, 1'b0);
    exp_q.push_back({id, rdata});
    tick();
    set_read(id, addr, 1'b0);
  endtask

  // Return the oldest outstanding read and check where it lands.
  task automatic return_read();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty observed=0 expected=nonzero");
    end else begin
      e = exp_q.pop_front();
      s_if.readdatavalid = 1'b1;
      s_if.readdata = e[DATA_W-1:0];
      #2;
      chk("rdv_m0", m0_if.readdatavalid, e[DATA_W] == 1'b0);
      chk("rdv_m1", m1_if.readdatavalid, e[DATA_W] == 1'b1);
      chk("rdata", e[DATA_W] ? m1_if.readdata : m0_if.readdata, e[DATA_W-1:0]);
      tick();
      s_if.readdatavalid = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    m0_if.address = '0; m0_if.writedata = '0;
    m1_if.address = '0; m1_if.writedata = '0;
    s_if.readdata = '0;
    idle_inputs();
    tick(); tick();
    rst_n = 1'b1;
    #2;
    exp_last = 1'b1;
    chk("rst_state", dbg_state, ARB_IDLE);
    chk("rst_count", dbg_count, 4'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_s_read", s_if.read, 1'b0);
    chk("rst_s_write", s_if.write, 1'b0);
    chk("rst_m0_wait", m0_if.waitrequest, 1'b1);
    chk("rst_m1_wait", m1_if.waitrequest, 1'b1);
    chk("rst_m0_rdv", m0_if.readdatavalid, 1'b0);
    tick();

    // Single read from m0, data one cycle later.
    issue_read(1'b0, 32'hAAAA1110, 32'hFEFEFEFE);
    exp_last = 1'b0;
    return_read();

    // Both requesters writing every cycle.
    m0_if.write = 1'b1; m0_if.address = 32'h1000_0000; m0_if.writedata = 32'h0000_00A0;
    m1_if.write = 1'b1; m1_if.address = 32'h2000_0000; m1_if.writedata = 32'h0000_00B1;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_w = 1'b0;
`else
      exp_w = ~exp_last;
`endif
      #2;
      chk("rr_addr", s_if.address, exp_w ? 32'h2000_0000 : 32'h1000_0000);
      chk("rr_wdata", s_if.writedata, exp_w ? 32'h0000_00B1 : 32'h0000_00A0);
      chk("rr_write", s_if.write, 1'b1);
      chk("rr_m0_wait", m0_if.waitrequest, exp_w != 1'b0);
      chk("rr_m1_wait", m1_if.waitrequest, exp_w != 1'b1);
      exp_last = exp_w;
      tick();
    end
    idle_inputs();
    tick();

    // m1 write stalled 3 cycles; m0 joins and must wait.
    m1_if.write = 1'b1; m1_if.address = 32'hBBBB2220;
    s_if.waitrequest = 1'b1;
    #2;
    chk("lk_m1_wait", m1_if.waitrequest, 1'b1);
    tick();
    m0_if.write = 1'b1; m0_if.address = 32'h3333_0000;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("lk_state", dbg_state, ARB_LOCKED);
      chk("lk_addr", s_if.address, 32'hBBBB2220);
      chk("lk_m0_wait", m0_if.waitrequest, 1'b1);
      tick();
    end
    s_if.waitrequest = 1'b0;
    #2;
    chk("lk_acc_addr", s_if.address, 32'hBBBB2220);
    chk("lk_acc_m1", m1_if.waitrequest, 1'b0);
    chk("lk_acc_m0", m0_if.waitrequest, 1'b1);
    tick();
    m1_if.write = 1'b0;
    #2;
    chk("lk_after_addr", s_if.address, 32'h3333_0000);
    chk("lk_after_m0", m0_if.waitrequest, 1'b0);
    tick();
    idle_inputs();

    // Fill the id FIFO with interleaved reads.
    for (int i = 0; i < MAX_OUT; i++) begin
      issue_read(req_id_t'(i % 2), 32'h5000_0000 + 32'(i * 4), $urandom_range(32'h7FFF_FFFF, 0));
    end
    m0_if.read = 1'b1; m0_if.address = 32'h5000_0100;
    m1_if.write = 1'b1; m1_if.address = 32'h6000_0000;
    #2;
    chk("full_count", dbg_count, 4'd8);
    chk("full_s_read", s_if.read, 1'b0);
    chk("full_m0_wait", m0_if.waitrequest, 1'b1);
    chk("full_s_write", s_if.write, 1'b1);
    chk("full_wr_addr", s_if.address, 32'h6000_0000);
    chk("full_m1_wait", m1_if.waitrequest, 1'b0);
    tick();
    idle_inputs();
    for (int i = 0; i < MAX_OUT - 1; i++) return_read();

    // Push and pop in the same cycle keep the count.
    ent = exp_q.pop_front();
    m0_if.read = 1'b1; m0_if.address = 32'h5000_0200;
    s_if.readdatavalid = 1'b1; s_if.readdata = ent[DATA_W-1:0];
    #2;
    chk("pp_rdv", ent[DATA_W] ? m1_if.readdatavalid : m0_if.readdatavalid, 1'b1);
    chk("pp_s_read", s_if.read, 1'b1);
    exp_q.push_back({1'b0, 32'h1234_5678});
    tick();
    idle_inputs();
    chk("pp_count", dbg_count, 4'd1);
    return_read();
    chk("drained", dbg_count, 4'd0);

    // read and write raised together: read only, error flagged.
    m0_if.read = 1'b1; m0_if.write = 1'b1; m0_if.address = 32'h4444_0000;
    #2;
    chk("rw_s_read", s_if.read, 1'b1);
    chk("rw_s_write", s_if.write, 1'b0);
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    tick();
    idle_inputs();
    chk("rw_err", err, 1'b1);
    return_read();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw_rst_err", err, 1'b0);

    // readdatavalid with nothing outstanding.
    s_if.readdatavalid = 1'b1; s_if.readdata = 32'hDEAD_BEEF;
    #2;
    chk("orph_m0", m0_if.readdatavalid, 1'b0);
    chk("orph_m1", m1_if.readdatavalid, 1'b0);
    tick();
    s_if.readdatavalid = 1'b0;
    chk("orph_err", err, 1'b1);
    tick(); tick(); tick();
    chk("orph_sticky", err, 1'b1);

    // Reset while locked with three reads outstanding.
    issue_read(1'b0, 32'h7000_0000, 32'h1);
    issue_read(1'b1, 32'h7000_0004, 32'h2);
    issue_read(1'b0, 32'h7000_0008, 32'h3);
    m1_if.write = 1'b1; m1_if.address = 32'h7100_0000;
    s_if.waitrequest = 1'b1;
    tick();
    chk("pre_state", dbg_state, ARB_LOCKED);
    chk("pre_count", dbg_count, 4'd3);
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    #2;
    chk("post_state", dbg_state, ARB_IDLE);
    chk("post_count", dbg_count, 4'd0);
    chk("post_err", err, 1'b0);
    chk("post_s_read", s_if.read, 1'b0);
    chk("post_s_write", s_if.write, 1'b0);
    chk("post_m1_wait", m1_if.waitrequest, 1'b1);
    tick();
    s_if.readdatavalid = 1'b1;
    #2;
    chk("late_m0", m0_if.readdatavalid, 1'b0);
    chk("late_m1", m1_if.readdatavalid, 1'b0);
    tick();
    s_if.readdatavalid = 1'b0;
    chk("late_err", err, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
